// File: rtl/cb_config_loader.sv
// cb_config_loader
// ----------------
// Word-serial configuration loader sitting in front of a connection block.
// Words arrive over a valid/ready handshake and are assembled in a shadow
// register. Once a full pattern is present it is copied onto the
// switch-control bus `c` in a single cycle. Because of this, the pass-gate
// switches never see a half-loaded pattern.
//
// Ports:
//   clk         in   1          sole clock, rising edge
//   rst         in   1          synchronous, active-high reset
//   cfg_start   in   1          begin (or restart) a load
//   cfg_valid   in   1          cfg_data holds a word
//   cfg_ready   out  1          loader accepts a word this cycle (LOAD state)
//   cfg_data    in   DIN_W      configuration word; first word -> lowest c bits
//   c           out  CFG_WIDTH  active switch-control bus
//   busy        out  1          LOAD or COMMIT in progress
//   done        out  1          last commit completed; held until next start
//   words_rcvd  out  CNT_W      words accepted in the current load
module cb_config_loader #(
  parameter  int CFG_WIDTH = 248,
  parameter  int DIN_W     = 8,
  localparam int NWORDS    = (CFG_WIDTH + DIN_W - 1) / DIN_W,
  localparam int CNT_W     = $clog2(NWORDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [DIN_W-1:0]     cfg_data,
  output logic [CFG_WIDTH-1:0] c,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     words_rcvd
);

  localparam int SH_W = NWORDS * DIN_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t               state_reg,  state_next;
  logic [SH_W-1:0]      shadow_reg, shadow_next;
  logic [CNT_W-1:0]     cnt_reg,    cnt_next;
  logic [CFG_WIDTH-1:0] c_reg,      c_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      shadow_reg <= '0;
      cnt_reg    <= '0;
      c_reg      <= '0;
    end else begin
      state_reg  <= state_next;
      shadow_reg <= shadow_next;
      cnt_reg    <= cnt_next;
      c_reg      <= c_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    shadow_next = shadow_reg;
    cnt_next    = cnt_reg;
    c_next      = c_reg;
    cfg_ready   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (cfg_start) begin
          state_next  = ST_LOAD;
          shadow_next = '0;
          cnt_next    = '0;
        end
      end

      ST_LOAD: begin
        cfg_ready = 1'b1;
        busy      = 1'b1;
        // A restart takes priority over a word offered in the same cycle;
        // that word is dropped and the load begins from scratch.
        if (cfg_start) begin
          shadow_next = '0;
          cnt_next    = '0;
        end else if (cfg_valid) begin
          // Shift right and insert at the top word: after NWORDS transfers
          // the first word received ends up in the lowest slot.
          shadow_next                    = shadow_reg >> DIN_W;
          shadow_next[SH_W-1 -: DIN_W]   = cfg_data;
          cnt_next                       = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(NWORDS - 1)) begin
            state_next = ST_COMMIT;
          end
        end
      end

      ST_COMMIT: begin
        busy = 1'b1;
        // Single-cycle atomic update of the switch bus; padding bits beyond
        // CFG_WIDTH in the last word are dropped here. Restarts are ignored.
        c_next     = shadow_reg[CFG_WIDTH-1:0];
        state_next = ST_DONE;
      end

      ST_DONE: begin
        done = 1'b1;
        if (cfg_start) begin
          state_next  = ST_LOAD;
          shadow_next = '0;
          cnt_next    = '0;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign c          = c_reg;
  assign words_rcvd = cnt_reg;

endmodule

// File: tb/tb_cb_config_loader.sv
// Testbench for cb_config_loader: randomized and directed loads checked
// against a placement model (word k lands in c[k*8 +: 8]), plus a second
// instance with CFG_WIDTH=10 to exercise padding of the last word.
module tb_cb_config_loader;

  localparam int W  = 248;
  localparam int D  = 8;
  localparam int N  = 31;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_start = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [D-1:0]  cfg_data  = '0;
  logic          cfg_ready, busy, done;
  logic [W-1:0]  c;
  logic [CW-1:0] words_rcvd;

  logic          p_start = 1'b0;
  logic          p_valid = 1'b0;
  logic [7:0]    p_data  = '0;
  logic          p_ready, p_busy, p_done;
  logic [9:0]    p_c;
  logic [1:0]    p_words;

  int vectors     = 0;
  int miscompares = 0;

  logic [D-1:0] load_words [N];

  always #5 clk = ~clk;

  cb_config_loader dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_data(cfg_data), .c(c), .busy(busy),
    .done(done), .words_rcvd(words_rcvd)
  );

  cb_config_loader #(.CFG_WIDTH(10), .DIN_W(8)) dut_pad (
    .clk(clk), .rst(rst), .cfg_start(p_start), .cfg_valid(p_valid),
    .cfg_ready(p_ready), .cfg_data(p_data), .c(p_c), .busy(p_busy),
    .done(p_done), .words_rcvd(p_words)
  );

  // Reference: word k of the stream occupies bits [k*D +: D] of the bus.
  function automatic logic [W-1:0] model_c();
    logic [N*D-1:0] acc;
    acc = '0;
    for (int k = 0; k < N; k++) acc[k*D +: D] = load_words[k];
    return acc[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one load of load_words. mode 0: back-to-back, 1: valid every
  // other cycle, 2: random gaps. Reports observations; callers judge them.
  // lat = edges from the edge that samples the last transfer until done=1.
  task automatic run_load(input bit do_start, input int mode,
                          output bit c_stable, output bit ready_ok,
                          output bit cnt_ok, output int lat);
    logic [W-1:0] c_before;
    int idx, cyc;
    c_before = c;
    c_stable = 1'b1;
    ready_ok = 1'b1;
    cnt_ok   = 1'b1;
    idx = 0;
    cyc = 0;
    if (do_start) begin
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
    end
    while (idx < N && cyc < 2000) begin
      case (mode)
        0:       cfg_valid = 1'b1;
        1:       cfg_valid = (cyc % 2 == 0);
        default: cfg_valid = ($urandom_range(0, 2) != 0);
      endcase
      cfg_data = load_words[idx];
      if (cfg_ready !== 1'b1) ready_ok = 1'b0;
      tick();
      if (cfg_valid) idx++;
      cyc++;
      if (words_rcvd !== CW'(idx)) cnt_ok = 1'b0;
      if (c !== c_before) c_stable = 1'b0;
    end
    cfg_valid = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 8) begin
      tick();
      lat++;
      if (done !== 1'b1 && c !== c_before) c_stable = 1'b0;
    end
    $display("load: %0d words in %0d cycles, done %0d edge(s) after last transfer",
             idx, cyc, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if (c !== '0 || done !== 1'b0 || cfg_ready !== 1'b0 || busy !== 1'b0 ||
        words_rcvd !== '0) begin
      miscompares++;
      $display("FAIL reset: c_zero=%0b done=%b ready=%b busy=%b words=%0d, required c=0 and all flags 0",
               (c === '0), done, cfg_ready, busy, words_rcvd);
    end
  endtask

  task automatic test_idle_ignore();
    cfg_valid = 1'b1;
    cfg_data  = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (c !== '0 || words_rcvd !== '0 || cfg_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_ignore[%0d]: c_zero=%0b words=%0d ready=%b, required c=0 words=0 ready=0",
                 i, (c === '0), words_rcvd, cfg_ready);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_full_load(input int mode, input string tag);
    bit cs, ro, co;
    int lat;
    logic [W-1:0] exp_c;
    for (int k = 0; k < N; k++) load_words[k] = D'(k);
    exp_c = model_c();
    run_load(1'b1, mode, cs, ro, co, lat);
    vectors++;
    if (c !== exp_c) begin
      miscompares++;
      $display("FAIL %s value: c=%h required %h", tag, c, exp_c);
    end
    vectors++;
    // Transfer cycle, then the COMMIT cycle: done shows after the next edge.
    if (lat !== 1) begin
      miscompares++;
      $display("FAIL %s latency: done after %0d edges, required 1", tag, lat);
    end
    vectors++;
    if (!cs || !ro || !co) begin
      miscompares++;
      $display("FAIL %s handshake: c_stable=%0b ready_ok=%0b count_ok=%0b, required 1/1/1",
               tag, cs, ro, co);
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b0 || words_rcvd !== CW'(N)) begin
      miscompares++;
      $display("FAIL %s final_flags: done=%b busy=%b ready=%b words=%0d, required 1 0 0 %0d",
               tag, done, busy, cfg_ready, words_rcvd, N);
    end
  endtask

  task automatic test_padding();
    p_start = 1'b1;
    tick();
    p_start = 1'b0;
    vectors++;
    if (p_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL pad_ready: ready=%b required 1", p_ready);
    end
    p_valid = 1'b1;
    p_data  = 8'hAB;
    tick();
    p_data  = 8'hFF;
    tick();
    p_valid = 1'b0;
    vectors++;
    if (p_c !== 10'h000 || p_done !== 1'b0) begin
      miscompares++;
      $display("FAIL pad_commit_cycle: c=%h done=%b required 000 0", p_c, p_done);
    end
    tick();
    vectors++;
    if (p_c !== 10'b11_1010_1011 || p_done !== 1'b1) begin
      miscompares++;
      $display("FAIL pad_value: c=%h done=%b required 3ab 1", p_c, p_done);
    end
  endtask

  task automatic test_abort();
    bit cs, ro, co;
    int lat;
    logic [W-1:0] exp_c;
    for (int k = 0; k < N; k++) load_words[k] = 8'hFF;
    run_load(1'b1, 0, cs, ro, co, lat);
    vectors++;
    if (c !== {W{1'b1}}) begin
      miscompares++;
      $display("FAIL abort_preload: c=%h required all ones", c);
    end
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cfg_data = D'($urandom);
      tick();
    end
    cfg_start = 1'b1;
    cfg_data  = 8'h33;
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    vectors++;
    if (words_rcvd !== '0 || c !== {W{1'b1}} || cfg_ready !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_restart: words=%0d c_ones=%0b ready=%b busy=%b, required 0 1 1 1",
               words_rcvd, (c === {W{1'b1}}), cfg_ready, busy);
    end
    for (int k = 0; k < N; k++) load_words[k] = 8'h5A;
    exp_c = model_c();
    run_load(1'b0, 0, cs, ro, co, lat);
    vectors++;
    if (c !== exp_c || !cs || !co) begin
      miscompares++;
      $display("FAIL abort_reload: c=%h c_stable=%0b count_ok=%0b, required %h 1 1",
               c, cs, co, exp_c);
    end
  endtask

  task automatic test_reset_mid_commit();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      cfg_data = D'($urandom);
      tick();
    end
    cfg_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0 || cfg_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL commit_state: busy=%b done=%b ready=%b, required 1 0 0",
               busy, done, cfg_ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (c !== '0 || done !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b0 ||
        words_rcvd !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_commit: c_zero=%0b done=%b busy=%b ready=%b words=%0d, required all 0",
               (c === '0), done, busy, cfg_ready, words_rcvd);
    end
  endtask

  task automatic test_random();
    bit cs, ro, co;
    int lat;
    logic [W-1:0] exp_c;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) load_words[k] = D'($urandom);
      exp_c = model_c();
      run_load(1'b1, 2, cs, ro, co, lat);
      vectors++;
      if (c !== exp_c || lat !== 1 || !cs || !co) begin
        miscompares++;
        $display("FAIL random[%0d]: c=%h lat=%0d c_stable=%0b count_ok=%0b, required %h 1 1 1",
                 r, c, lat, cs, co, exp_c);
      end
      // Words offered while DONE must be ignored.
      cfg_valid = 1'b1;
      cfg_data  = D'($urandom);
      tick();
      tick();
      cfg_valid = 1'b0;
      vectors++;
      if (c !== exp_c || done !== 1'b1 || words_rcvd !== CW'(N)) begin
        miscompares++;
        $display("FAIL random_done_hold[%0d]: c=%h done=%b words=%0d, required %h 1 %0d",
                 r, c, done, words_rcvd, exp_c, N);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_full_load(0, "full_load");
    test_full_load(1, "stalled");
    test_padding();
    test_abort();
    test_reset_mid_commit();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
